// File: rtl/fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch front end.
// Holds the reset PC default, FSM state encodings and buffer entry layout.
package fetch_unit_pkg;
   localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES    = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with clear; used as the fetch buffer and
// as the in-order PC queue of outstanding requests.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A push at full is allowed when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt_ptr(wr_ptr);
         end
         if (do_pop)
            rd_ptr <= nxt_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// buffering with PCs, redirect flush and drain of stale in-flight responses.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_F,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] PC_F,
   output logic [31:0] imem_data,
   output logic        valid_F
);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e  state, state_nxt;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] out_cnt, discard_cnt, remain_cnt;
   logic [CW-1:0] buf_cnt, pcq_cnt;
   logic [CW:0]   credit_sum;
   logic          buf_full, buf_empty, pcq_full, pcq_empty;
   logic          req_fire, rsp_hit, buf_push, buf_pop;
   logic [31:0]   pcq_head;
   fetch_entry_t  buf_din, buf_head;
   logic          unused_ok;

   // Responses in BOOT or with nothing outstanding are not ours.
   assign rsp_hit    = imem_rsp_valid && !rst && (state != ST_BOOT) && (out_cnt != '0);
   assign remain_cnt = out_cnt - CW'(rsp_hit);
   assign credit_sum = {1'b0, out_cnt} + {1'b0, buf_cnt};

   assign imem_req_valid = !rst && (state == ST_FETCH) && !redirect_valid &&
                           (credit_sum < (CW+1)'(DEPTH));
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign buf_push = rsp_hit && (state == ST_FETCH) && !redirect_valid;
   assign buf_pop  = valid_F && !stall_F;
   assign buf_din  = '{pc: pcq_head, instr: imem_rsp_data};

   assign valid_F   = !rst && !buf_empty;
   assign PC_F      = valid_F ? buf_head.pc    : 32'h0;
   assign imem_data = valid_F ? buf_head.instr : 32'h0;

   // PC of every accepted request, consumed as its response is buffered.
   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pcq (
      .clk   (clk),
      .rst   (rst),
      .push  (req_fire),
      .din   (fetch_pc),
      .pop   (buf_push),
      .clear (redirect_valid),
      .dout  (pcq_head),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_cnt)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (buf_push),
      .din   (buf_din),
      .pop   (buf_pop),
      .clear (redirect_valid),
      .dout  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_cnt)
   );

   assign unused_ok = &{1'b0, buf_full, pcq_full, pcq_empty, pcq_cnt};

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_BOOT:  state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_FETCH;
         ST_DRAIN: if (rsp_hit && discard_cnt == CW'(1)) state_nxt = ST_FETCH;
         default:  state_nxt = ST_BOOT;
      endcase
      if (redirect_valid)
         state_nxt = (remain_cnt != '0) ? ST_DRAIN : ST_FETCH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_BOOT;
         fetch_pc    <= word_align(RESET_PC);
         out_cnt     <= '0;
         discard_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            // Everything still in flight is stale and must be swallowed.
            fetch_pc    <= word_align(redirect_pc);
            out_cnt     <= remain_cnt;
            discard_cnt <= remain_cnt;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + WORD_BYTES;
            out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_hit);
            if (state == ST_DRAIN && rsp_hit)
               discard_cnt <= discard_cnt - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirects,
// backpressure, PC wrap and mid-transaction reset.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall_F, redirect_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] redirect_pc, imem_rsp_data;
   logic        imem_req_valid, valid_F;
   logic [31:0] imem_addr, PC_F, imem_data;

   logic        d2_req_valid, d2_rsp_valid, d2_valid;
   logic [31:0] d2_addr, d2_pc, d2_data;

   fetch_unit u_dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .PC_F(PC_F), .imem_data(imem_data), .valid_F(valid_F)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .stall_F(1'b0), .redirect_valid(1'b0),
      .redirect_pc(32'h0), .imem_req_valid(d2_req_valid),
      .imem_req_ready(1'b1), .imem_addr(d2_addr),
      .imem_rsp_valid(d2_rsp_valid), .imem_rsp_data(32'h0),
      .PC_F(d2_pc), .imem_data(d2_data), .valid_F(d2_valid)
   );

   int          n_chk = 0, n_err = 0, n_acc = 0;
   logic [31:0] mq[$];
   logic [31:0] d2_log[$];
   logic [31:0] exp_pc, nxt_req, hold, tmp;
   logic        rsp_en, mon_en, req_chk, out_chk, d2_pend, found;
   int          waited, rem, base;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Memory answers the oldest accepted request, one per cycle, when enabled.
   task automatic drive();
      if (rsp_en && mq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mdata(mq[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      d2_rsp_valid = d2_pend;
      #1;
   endtask

   task automatic adv();
      if (mon_en && valid_F && !stall_F && !redirect_valid && !rst) begin
         chk("pop_pc", PC_F, exp_pc);
         chk("pop_dat", imem_data, mdata(exp_pc));
         exp_pc += 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
         if (req_chk) chk("req_addr", imem_addr, nxt_req);
         nxt_req += 32'd4;
         n_acc++;
         mq.push_back(imem_addr);
      end
      if (imem_rsp_valid) tmp = mq.pop_front();
      if (out_chk) chk("out_le2", 32'(mq.size() <= 2), 32'd1);
      if (!rst && d2_req_valid && d2_log.size() < 3) d2_log.push_back(d2_addr);
      d2_pend = d2_req_valid && !rst;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         adv();
      end
   endtask

   initial begin
      rst = 1'b1; stall_F = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      d2_rsp_valid = 1'b0; d2_pend = 1'b0;
      rsp_en = 1'b1; mon_en = 1'b0; req_chk = 1'b0; out_chk = 1'b0;
      exp_pc = 32'h0; nxt_req = 32'h0; tmp = 32'h0;
      @(negedge clk);
      run(1);
      drive();
      chk("rst_req", 32'(imem_req_valid), 32'd0);
      chk("rst_vld", 32'(valid_F), 32'd0);
      chk("rst_pc", PC_F, 32'h0);
      chk("rst_dat", imem_data, 32'h0);
      chk("d2_rst_vld", 32'(d2_valid), 32'd0);
      chk("d2_rst_pc", d2_pc, 32'h0);
      chk("d2_rst_dat", d2_data, 32'h0);
      adv();

      // Reset release: BOOT cycle, then requests 0,4,...; first head after 3 edges.
      rst = 1'b0; mon_en = 1'b1; req_chk = 1'b1;
      drive();
      chk("boot_req", 32'(imem_req_valid), 32'd0);
      chk("boot_vld", 32'(valid_F), 32'd0);
      chk("boot_pc", PC_F, 32'h0);
      adv();
      drive();
      chk("first_req", 32'(imem_req_valid), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      adv();
      drive();
      chk("vld_c", 32'(valid_F), 32'd0);
      adv();
      drive();
      chk("vld_d", 32'(valid_F), 32'd1);
      chk("head_pc", PC_F, 32'h0);
      adv();
      run(10);
      chk("stream_pops", 32'(exp_pc >= 32'h10), 32'd1);
      chk("d2_n", 32'(d2_log.size()), 32'd3);
      if (d2_log.size() == 3) begin
         chk("d2_a0", d2_log[0], 32'hFFFF_FFF8);
         chk("d2_a1", d2_log[1], 32'hFFFF_FFFC);
         chk("d2_a2", d2_log[2], 32'h0000_0000);
      end

      // Stall with a full buffer: no requests, head frozen.
      stall_F = 1'b1;
      run(4);
      for (int i = 0; i < 5; i++) begin
         drive();
         chk("st_req", 32'(imem_req_valid), 32'd0);
         chk("st_vld", 32'(valid_F), 32'd1);
         chk("st_pc", PC_F, exp_pc);
         chk("st_dat", imem_data, mdata(exp_pc));
         adv();
      end
      stall_F = 1'b0;
      run(8);

      // Redirect with two requests in flight.
      rsp_en = 1'b0;
      run(4);
      chk("rd_inflight", 32'(mq.size()), 32'd2);
      chk("rd_empty", 32'(valid_F), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      drive();
      chk("rd_req", 32'(imem_req_valid), 32'd0);
      adv();
      redirect_valid = 1'b0; rsp_en = 1'b1;
      exp_pc = 32'h100; nxt_req = 32'h100;
      found = 1'b0; waited = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         drive();
         if (imem_req_valid) begin
            found = 1'b1;
            chk("rd_addr", imem_addr, 32'h100);
         end else waited++;
         adv();
      end
      chk("rd_found", 32'(found), 32'd1);
      chk("drain_cyc", 32'(waited), 32'd2);
      run(6);
      chk("rd_pops", 32'(exp_pc > 32'h100), 32'd1);

      // Redirect coinciding with a response and a pop.
      found = 1'b0; rem = -1;
      for (int i = 0; i < 10 && !found; i++) begin
         drive();
         if (valid_F && imem_rsp_valid) begin
            found = 1'b1;
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
            #1;
            rem = mq.size() - 1;
         end
         adv();
      end
      chk("co_found", 32'(found), 32'd1);
      redirect_valid = 1'b0; exp_pc = 32'h200; nxt_req = 32'h200;
      drive();
      chk("co_vld", 32'(valid_F), 32'd0);
      chk("co_req", 32'(imem_req_valid), 32'(rem == 0));
      if (rem == 0) chk("co_addr", imem_addr, 32'h200);
      adv();
      run(6);

      // Backpressure: address held while not ready, then exactly one accept.
      imem_req_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         drive();
         if (imem_req_valid) found = 1'b1;
         else adv();
      end
      chk("bp_found", 32'(found), 32'd1);
      hold = nxt_req; base = n_acc;
      for (int i = 0; i < 3; i++) begin
         chk("bp_v", 32'(imem_req_valid), 32'd1);
         chk("bp_addr", imem_addr, hold);
         chk("bp_out", 32'(mq.size() <= 2), 32'd1);
         adv();
         drive();
      end
      imem_req_ready = 1'b1;
      #1;
      chk("bp_acc_addr", imem_addr, hold);
      adv();
      chk("bp_single", 32'(n_acc - base), 32'd1);
      out_chk = 1'b1;
      run(6);
      out_chk = 1'b0;

      // Reset with requests outstanding; stale responses land in rst/BOOT.
      rsp_en = 1'b0;
      run(3);
      chk("mr_inflight", 32'(mq.size() > 0), 32'd1);
      rst = 1'b1; rsp_en = 1'b1; mon_en = 1'b0; req_chk = 1'b0;
      drive();
      chk("mr_req", 32'(imem_req_valid), 32'd0);
      adv();
      rst = 1'b0;
      drive();
      chk("mr_boot_vld", 32'(valid_F), 32'd0);
      chk("mr_boot_req", 32'(imem_req_valid), 32'd0);
      adv();
      mq.delete();
      exp_pc = 32'h0; nxt_req = 32'h0; mon_en = 1'b1; req_chk = 1'b1;
      run(8);
      chk("mr_pops", 32'(exp_pc >= 32'h8), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
